// File: rtl/gamepad_multi_pkg.sv
// Shared constants for the multi-controller TT Gamepad Pmod peripheral.
// Holds the register address map, the per-controller bit count and the
// CTRL register bit positions, plus a helper that forms the byte address
// of an indexed register (STATE i / EVENTS i).
package gamepad_multi_pkg;

    localparam int CTRL_BITS = 12;

    localparam logic [5:0] ADDR_CTRL       = 6'h00;
    localparam logic [5:0] ADDR_STATUS     = 6'h04;
    localparam logic [5:0] ADDR_STATE_BASE = 6'h10;
    localparam logic [5:0] ADDR_EVENT_BASE = 6'h20;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // Indexed registers are word-spaced from their base.
    function automatic logic [5:0] reg_addr(input logic [5:0] base, input int idx);
        return base + 6'(idx * 4);
    endfunction

endpackage

// File: rtl/gamepad_serial_rx.sv
// Pmod serial front end: synchronises data/clk/latch, detects rising edges
// and shifts the data stream into a WIDTH-bit register.
// Ports:
//   clk, rst_n     - system clock, synchronous active-low reset
//   i_pmod_data    - serial data pin (asynchronous)
//   i_pmod_clk     - serial clock pin (asynchronous)
//   i_pmod_latch   - frame latch pin (asynchronous)
//   o_shift        - current shift register contents (first bit sent is MSB)
//   o_latch_pulse  - one-cycle pulse on a synchronised latch rising edge
module gamepad_serial_rx
    import gamepad_multi_pkg::*;
#(
    parameter int WIDTH = 2 * CTRL_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_pmod_data,
    input  logic             i_pmod_clk,
    input  logic             i_pmod_latch,
    output logic [WIDTH-1:0] o_shift,
    output logic             o_latch_pulse
);

    // Synchroniser bit order: [2]=data, [1]=clk, [0]=latch.
    // Data travels through the same two flops as clk so it is aligned with
    // the detected clk edge.
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [1:0]       r_prev;      // [1]=clk, [0]=latch
    logic [WIDTH-1:0] r_shift;
    logic             w_clk_rise;

    assign w_clk_rise    = r_sync2[1] & ~r_prev[1];
    // Combinational pulse so the capture lands on the third clk edge after
    // the latch pin rises.
    assign o_latch_pulse = r_sync2[0] & ~r_prev[0];
    assign o_shift       = r_shift;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_shift <= '1;
        end else begin
            r_sync1 <= {i_pmod_data, i_pmod_clk, i_pmod_latch};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2[1:0];
            if (w_clk_rise) begin
                r_shift <= {r_shift[WIDTH-2:0], r_sync2[2]};
            end
        end
    end

endmodule

// File: rtl/tqvp_gamepad_multi.sv
// TinyQV peripheral for a chain of NUM_CTRL TT Gamepad controllers.
// Captures each latched frame, reports button state and presence, records
// sticky press/release events (write-1-to-clear) with a level interrupt and
// runs a frame watchdog that blanks the captured data when latching stops.
// Ports:
//   clk, rst_n      - system clock, synchronous active-low reset
//   ui_in           - [6]=pmod_data, [5]=pmod_clk, [4]=pmod_latch
//   uo_out          - tied 0
//   address         - byte address within the peripheral
//   data_in         - write data
//   data_write_n    - 2'b11 = no write, otherwise write
//   data_read_n     - read strobe (reads are combinational, so unused)
//   data_out        - read data, combinational from address
//   data_ready      - constant 1
//   user_interrupt  - irq_en and any event bit set
module tqvp_gamepad_multi
    import gamepad_multi_pkg::*;
#(
    parameter int NUM_CTRL       = 2,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    localparam int W    = NUM_CTRL * CTRL_BITS;
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    logic [W-1:0]      w_shift;
    logic              w_latch_pulse;
    logic              w_accept;
    logic              w_write;
    logic [W-1:0]      r_cap;
    logic [W-1:0]      r_prev_cap;
    logic [WD_W-1:0]   r_wd;
    logic              r_stale;
    logic              r_enable;
    logic              r_irq_en;
    logic [15:0]       r_frame_count;
    logic [W-1:0]      r_press_ev;
    logic [W-1:0]      r_release_ev;
    logic [W-1:0]      w_press_set;
    logic [W-1:0]      w_release_set;
    logic [W-1:0]      w_press_clr;
    logic [W-1:0]      w_release_clr;
    logic [NUM_CTRL-1:0] w_present;
    logic [3:0]        w_present_4;
    logic              w_unused;

    gamepad_serial_rx #(.WIDTH(W)) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_pmod_data  (ui_in[6]),
        .i_pmod_clk   (ui_in[5]),
        .i_pmod_latch (ui_in[4]),
        .o_shift      (w_shift),
        .o_latch_pulse(w_latch_pulse)
    );

    assign w_accept    = w_latch_pulse & r_enable;
    assign w_write     = (data_write_n != 2'b11);
    assign w_present_4 = 4'(w_present);

    // Per-controller presence, event detection and W1C clear masks.
    for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
        logic [CTRL_BITS-1:0] w_new;
        logic [CTRL_BITS-1:0] w_old;
        logic                 w_both_present;
        logic                 w_clr_sel;

        assign w_new          = r_cap[gi*CTRL_BITS +: CTRL_BITS];
        assign w_old          = r_prev_cap[gi*CTRL_BITS +: CTRL_BITS];
        assign w_present[gi]  = (w_new != '1);
        // Plugging or unplugging a controller must not look like button activity.
        assign w_both_present = w_present[gi] & (w_old != '1);
        assign w_clr_sel      = w_write && (address == reg_addr(ADDR_EVENT_BASE, gi));

        assign w_press_set[gi*CTRL_BITS +: CTRL_BITS]   = w_both_present ? (w_new & ~w_old) : '0;
        assign w_release_set[gi*CTRL_BITS +: CTRL_BITS] = w_both_present ? (~w_new & w_old) : '0;
        assign w_press_clr[gi*CTRL_BITS +: CTRL_BITS]   = w_clr_sel ? data_in[11:0]  : '0;
        assign w_release_clr[gi*CTRL_BITS +: CTRL_BITS] = w_clr_sel ? data_in[27:16] : '0;
    end

    // Control, capture, watchdog and frame counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_enable      <= 1'b0;
            r_irq_en      <= 1'b0;
            r_cap         <= '1;
            r_prev_cap    <= '1;
            r_wd          <= '0;
            r_stale       <= 1'b0;
            r_frame_count <= '0;
        end else begin
            if (w_write && address == ADDR_CTRL) begin
                r_enable <= data_in[CTRL_ENABLE_BIT];
                r_irq_en <= data_in[CTRL_IRQ_EN_BIT];
            end
            // Tracks cap one cycle behind so events see each change exactly once.
            r_prev_cap <= r_cap;
            if (w_accept) begin
                r_cap         <= w_shift;
                r_stale       <= 1'b0;
                r_wd          <= '0;
                r_frame_count <= r_frame_count + 16'd1;
            end else if (!r_enable) begin
                r_wd <= '0;
            end else if (r_wd != WD_MAX) begin
                r_wd <= r_wd + 1'b1;
                if (r_wd == WD_MAX - 1'b1) begin
                    r_cap   <= '1;
                    r_stale <= 1'b1;
                end
            end
        end
    end

    // Sticky events: a set in the same cycle as a clear of that bit wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_press_ev   <= '0;
            r_release_ev <= '0;
        end else begin
            r_press_ev   <= (r_press_ev & ~w_press_clr) | w_press_set;
            r_release_ev <= (r_release_ev & ~w_release_clr) | w_release_set;
        end
    end

    always_comb begin
        data_out = '0;
        if (address == ADDR_CTRL) begin
            data_out = {30'h0, r_irq_en, r_enable};
        end else if (address == ADDR_STATUS) begin
            data_out = {r_frame_count, 7'h0, r_stale, 4'h0, w_present_4};
        end
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (address == reg_addr(ADDR_STATE_BASE, i)) begin
                data_out = {20'h0, r_cap[i*CTRL_BITS +: CTRL_BITS]};
            end
            if (address == reg_addr(ADDR_EVENT_BASE, i)) begin
                data_out = {4'h0, r_release_ev[i*CTRL_BITS +: CTRL_BITS],
                            4'h0, r_press_ev[i*CTRL_BITS +: CTRL_BITS]};
            end
        end
    end

    assign uo_out         = 8'h00;
    assign data_ready     = 1'b1;
    assign user_interrupt = r_irq_en & ((|r_press_ev) | (|r_release_ev));

    // Pins and bus fields with no function in this peripheral.
    assign w_unused = &{1'b0, data_read_n, ui_in, data_in};

endmodule

// File: tb/tb_tqvp_gamepad_multi.sv
module tb_tqvp_gamepad_multi;

    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_STATUS = 6'h04;
    localparam logic [5:0] A_UNMAP  = 6'h08;
    localparam logic [5:0] A_ST0    = 6'h10;
    localparam logic [5:0] A_ST1    = 6'h14;
    localparam logic [5:0] A_ST2    = 6'h18;
    localparam logic [5:0] A_EV0    = 6'h20;
    localparam logic [5:0] A_EV1    = 6'h24;
    localparam logic [5:0] A_EV2    = 6'h28;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [23:0] frame;
        logic [11:0] st0;
        logic [11:0] st1;
        logic [3:0]  pres;
        logic [31:0] ev0;
        logic [31:0] ev1;
        logic [15:0] fc;
        logic        irq;
    } vec_t;

    vec_t vecs[4];

    always #50 clk = ~clk;

    tqvp_gamepad_multi #(
        .NUM_CTRL(2),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ui_in         (ui_in),
        .uo_out        (uo_out),
        .address       (address),
        .data_in       (data_in),
        .data_write_n  (data_write_n),
        .data_read_n   (data_read_n),
        .data_out      (data_out),
        .data_ready    (data_ready),
        .user_interrupt(user_interrupt)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h required %h", name, got, exp);
        end else begin
            $display("[TB] ok   %s = %h", name, got);
        end
    endtask

    task automatic check_reg(input string name, input logic [5:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(name, data_out, exp);
    endtask

    task automatic check_irq(input string name, input logic exp);
        #1;
        check(name, {31'h0, user_interrupt}, {31'h0, exp});
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        address      = a;
        data_in      = d;
        data_write_n = 2'b00;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    // Sends n bits of v (bit n-1 first) then pulses latch. Returns three
    // cycles after the capture edge. With collide=1 a W1C of EVENTS0 bit0 is
    // held across the edge where events from this frame are recorded.
    task automatic send_frame(input logic [23:0] v, input int n, input logic collide);
        for (int b = n - 1; b >= 0; b--) begin
            @(negedge clk);
            ui_in[6] = v[b];
            ui_in[5] = 1'b0;
            @(negedge clk);
            ui_in[5] = 1'b1;
        end
        @(negedge clk);
        ui_in[5] = 1'b0;
        ui_in[6] = 1'b0;
        ui_in[4] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ui_in[4] = 1'b0;
        @(negedge clk);
        if (collide) begin
            address      = A_EV0;
            data_in      = 32'h0000_0001;
            data_write_n = 2'b00;
        end
        @(negedge clk);
        data_write_n = 2'b11;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #50_000_000;
        $display("[TB] FAIL global_timeout: got still running, required finished");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{24'h00A005, 12'h005, 12'h00A, 4'b0011, 32'h0000_0000, 32'h0000_0000, 16'd1, 1'b0};
        vecs[1] = '{24'h00C006, 12'h006, 12'h00C, 4'b0011, 32'h0001_0002, 32'h0002_0004, 16'd2, 1'b1};
        vecs[2] = '{24'hFFF000, 12'h000, 12'hFFF, 4'b0001, 32'h0006_0000, 32'h0000_0000, 16'd3, 1'b1};
        vecs[3] = '{24'h000003, 12'h003, 12'h000, 4'b0011, 32'h0000_0003, 32'h0000_0000, 16'd4, 1'b1};

        ui_in        = 8'h00;
        address      = 6'h00;
        data_in      = 32'h0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check_reg("rst_ctrl", A_CTRL, 32'h0);
        check_reg("rst_status", A_STATUS, 32'h0);
        check_reg("rst_state0", A_ST0, 32'h0000_0FFF);
        check_reg("rst_state1", A_ST1, 32'h0000_0FFF);
        check_reg("rst_events0", A_EV0, 32'h0);
        check_irq("rst_irq", 1'b0);
        check("uo_out", {24'h0, uo_out}, 32'h0);
        check("data_ready", {31'h0, data_ready}, 32'h1);

        bus_write(A_CTRL, 32'h3);
        check_reg("ctrl_rw", A_CTRL, 32'h3);

        // Table-driven frames
        for (int k = 0; k < 4; k++) begin
            send_frame(vecs[k].frame, 24, 1'b0);
            check_reg($sformatf("v%0d_state0", k), A_ST0, {20'h0, vecs[k].st0});
            check_reg($sformatf("v%0d_state1", k), A_ST1, {20'h0, vecs[k].st1});
            check_reg($sformatf("v%0d_status", k), A_STATUS, {vecs[k].fc, 7'h0, 1'b0, 4'h0, vecs[k].pres});
            check_reg($sformatf("v%0d_events0", k), A_EV0, vecs[k].ev0);
            check_reg($sformatf("v%0d_events1", k), A_EV1, vecs[k].ev1);
            check_irq($sformatf("v%0d_irq", k), vecs[k].irq);
            bus_write(A_EV0, 32'hFFFF_FFFF);
            bus_write(A_EV1, 32'hFFFF_FFFF);
        end

        // Press then partial W1C clearing
        send_frame(24'h000000, 24, 1'b0);
        bus_write(A_EV0, 32'hFFFF_FFFF);
        bus_write(A_EV1, 32'hFFFF_FFFF);
        send_frame(24'h000003, 24, 1'b0);
        check_reg("press_events0", A_EV0, 32'h0000_0003);
        check_reg("press_events1", A_EV1, 32'h0);
        check_irq("press_irq", 1'b1);
        bus_write(A_EV0, 32'h1);
        check_reg("w1c_bit0", A_EV0, 32'h0000_0002);
        check_irq("w1c_bit0_irq", 1'b1);
        bus_write(A_EV0, 32'h2);
        check_reg("w1c_bit1", A_EV0, 32'h0);
        check_irq("w1c_bit1_irq", 1'b0);

        // Set and clear of the same bit in one cycle
        send_frame(24'h000000, 24, 1'b0);
        bus_write(A_EV0, 32'hFFFF_FFFF);
        check_reg("pre_collide_events0", A_EV0, 32'h0);
        send_frame(24'h000001, 24, 1'b1);
        check_reg("collide_events0", A_EV0, 32'h0000_0001);

        // Watchdog: capture edge A, task returns after A+3
        send_frame(24'h00A005, 24, 1'b0);
        repeat (96) @(negedge clk);
        check_reg("wd99_status", A_STATUS, 32'h0009_0003);
        check_reg("wd99_state0", A_ST0, 32'h0000_0005);
        @(negedge clk);
        check_reg("wd100_status", A_STATUS, 32'h0009_0100);
        check_reg("wd100_state0", A_ST0, 32'h0000_0FFF);
        check_reg("wd100_state1", A_ST1, 32'h0000_0FFF);
        check_reg("wd100_events0", A_EV0, 32'h0000_0005);
        check_reg("wd100_events1", A_EV1, 32'h0000_000A);
        send_frame(24'h00A005, 24, 1'b0);
        check_reg("wd_relatch_status", A_STATUS, 32'h000A_0003);
        check_reg("wd_relatch_state0", A_ST0, 32'h0000_0005);

        // Disabled: latched frame ignored
        bus_write(A_CTRL, 32'h2);
        check_reg("dis_ctrl", A_CTRL, 32'h2);
        send_frame(24'h123456, 24, 1'b0);
        check_reg("dis_state0", A_ST0, 32'h0000_0005);
        check_reg("dis_state1", A_ST1, 32'h0000_000A);
        check_reg("dis_status", A_STATUS, 32'h000A_0003);
        check_reg("dis_events0", A_EV0, 32'h0000_0005);
        check_reg("dis_events1", A_EV1, 32'h0000_000A);
        check_irq("dis_irq", 1'b1);

        // Out-of-range and unmapped registers
        check_reg("unmap_state2", A_ST2, 32'h0);
        check_reg("unmap_events2", A_EV2, 32'h0);
        check_reg("unmap_08", A_UNMAP, 32'h0);

        // Reset mid-shift
        bus_write(A_CTRL, 32'h3);
        for (int b = 0; b < 10; b++) begin
            @(negedge clk);
            ui_in[6] = b[0];
            ui_in[5] = 1'b0;
            @(negedge clk);
            ui_in[5] = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        ui_in = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_reg("mrst_ctrl", A_CTRL, 32'h0);
        check_reg("mrst_status", A_STATUS, 32'h0);
        check_reg("mrst_state0", A_ST0, 32'h0000_0FFF);
        check_reg("mrst_state1", A_ST1, 32'h0000_0FFF);
        check_reg("mrst_events0", A_EV0, 32'h0);
        check_reg("mrst_events1", A_EV1, 32'h0);
        check_irq("mrst_irq", 1'b0);

        // Single controller into the all-ones chain, then a full frame
        bus_write(A_CTRL, 32'h3);
        send_frame(24'h000001, 12, 1'b0);
        check_reg("single_state0", A_ST0, 32'h0000_0001);
        check_reg("single_state1", A_ST1, 32'h0000_0FFF);
        check_reg("single_status", A_STATUS, 32'h0001_0001);
        check_reg("single_events0", A_EV0, 32'h0);
        check_reg("single_events1", A_EV1, 32'h0);
        send_frame(24'h00A005, 24, 1'b0);
        check_reg("after_state0", A_ST0, 32'h0000_0005);
        check_reg("after_state1", A_ST1, 32'h0000_000A);
        check_reg("after_status", A_STATUS, 32'h0002_0003);
        check_reg("after_events0", A_EV0, 32'h0000_0004);
        check_reg("after_events1", A_EV1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tqvp_gamepad_multi.md
Name: tqvp_gamepad_multi

Overview:
- Next-generation TinyQV peripheral for the TT Gamepad Pmod.
- Deserialises a chain of NUM_CTRL 12-bit controllers from the Pmod serial stream and reports per-controller button state and presence.
- Adds sticky press/release event registers with write-1-to-clear and a level interrupt.
- Adds a frame watchdog that declares controllers absent when the Pmod stops latching.
- Sits on the TinyQV peripheral bus with one-cycle reads; pins arrive on ui_in.

Parameters:
- NUM_CTRL, 2, number of chained controllers; legal range 1..4.
- CTRL_BITS, 12, bits per controller; fixed by the Pmod protocol, not overridden.
- TIMEOUT_CYCLES, 2000000, clk cycles without a latch rising edge before all captured data is forced to all-ones; legal range >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- ui_in  in  8  [6]=pmod_data, [5]=pmod_clk, [4]=pmod_latch; other bits unused
- uo_out  out  8  tied 0
- address  in  6  byte address within the peripheral
- data_in  in  32  write data
- data_write_n  in  2  11=no write, else write of any width
- data_read_n  in  2  11=no read, else read; unused
- data_out  out  32  read data, combinational from address
- data_ready  out  1  constant 1
- user_interrupt  out  1  irq_en & (|all event bits)

Behaviour:
- Sync: data/clk/latch each pass a 2-flop synchroniser, then a prev flop for edge detection.
  - Reset: synchroniser flops and prev flops = 0.
- Shift register: W=NUM_CTRL*12 bits, reset all-ones.
  - On each synchronised pmod_clk rising edge: shift left, LSB <= data.
  - Surplus bits fall off the MSB.
- Capture: on synchronised latch rising edge with enable=1, cap <= shift.
  - cap is updated on the 3rd clk edge after the latch pin rises, counting the edges that sample it.
  - Latch edges with enable=0 are ignored, including for the watchdog.
  - cap reset value is all-ones.
- Controller i occupies cap[12i+11:12i].
  - present[i] = (slice != 12'hfff).
  - Button bit = 1 means pressed.
- Watchdog: counter wd, reset 0.
  - wd clears on every accepted latch edge or while enable=0; otherwise increments, saturating at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: cap <= all-ones, stale=1.
  - Any accepted latch clears stale.
  - Shift register is not touched by the watchdog.
- Events: registered copy prev_cap, reset all-ones, updated in the cycle after each cap change.
  - press_ev[i] |= new & ~old; release_ev[i] |= ~new & old.
  - Computed only when both old and new slices are present; a present<->absent transition sets no events.
  - Events are evaluated one cycle after cap updates.
- Clearing: a write to an event register clears the bits set in data_in.
  - On a simultaneous set and clear of the same bit, the set wins.
- Address map (byte address; any write width acts on all written bits):
  - 0x00 CTRL: rw; [0]=enable (reset 0), [1]=irq_en (reset 0).
  - 0x04 STATUS: ro; [3:0]=present (upper bits 0 beyond NUM_CTRL), [8]=stale, [31:16]=frame_count.
    - frame_count: accepted latch edges, wraps at 16'hffff to 0, reset 0.
  - 0x10+4i STATE i: ro; {20'h0, slice i}.
  - 0x20+4i EVENTS i: {4'h0, release_ev[i], 4'h0, press_ev[i]}; W1C.
  - Registers for i >= NUM_CTRL, and all other addresses, read 0; writes to them are ignored.
- Disable behaviour: setting enable=0 freezes cap, does not clear events, and clears wd.
- Reset mid-frame returns every register to its reset value; the next full frame after release captures normally.

Decomposition:
- Package gamepad_multi_pkg: address constants (ADDR_CTRL, ADDR_STATUS, ADDR_STATE_BASE, ADDR_EVENT_BASE), CTRL_BITS=12, CTRL bit indices.
- Sub-module gamepad_serial_rx #(WIDTH): synchroniser, edge detection, shift register.
  - Outputs shift data and a one-cycle latch_pulse.
- Top level holds capture, watchdog, events, bus decode and interrupt.

Test Plan:
- NUM_CTRL=2, enable=1, send 24 bits 0x00A_005 then latch:
  - STATE0=0x005, STATE1=0x00A, STATUS[1:0]=2'b11, frame_count=1.
- Single controller sends 12 bits 0x001 into the 24-bit chain (prior all-ones):
  - STATE0=0x001, STATE1=0xFFF, present=2'b01, no events for ctrl1.
- Frame 0x000 then frame 0x003 on ctrl0 with irq_en=1:
  - EVENTS0=0x0000_0003, user_interrupt=1.
  - Write 0x1 -> EVENTS0=0x0000_0002, irq stays 1.
  - Write 0x2 -> EVENTS0=0, irq=0.
- W1C write of bit0 in the same cycle a press on bit0 is recorded -> bit0 remains 1.
- TIMEOUT_CYCLES=100, one frame then silence:
  - at wd=100, STATE*=0xFFF, stale=1, present=0.
  - Next latch clears stale.
- enable=0 during a latched frame -> cap, frame_count and events unchanged.
  - Assert rst_n low mid-shift -> all regs at reset values; the following full frame captures correctly.
